// File: rtl/mpeg_fifo_pkg.sv
// Shared types for the MPEG input-stream FIFO controller: address/level widths,
// write-side state encoding and the RAM-word byte-order helper.
package mpeg_fifo_pkg;

  localparam int FIFO_ABITS = 15;

  typedef logic [FIFO_ABITS-1:0] byte_addr_t;
  typedef logic [FIFO_ABITS-3:0] word_addr_t;
  typedef logic [FIFO_ABITS:0]   level_t;

  typedef enum logic {
    IDLE = 1'b0,
    PAD  = 1'b1
  } fifo_wr_state_e;

  // The RAM stores byte 0 of a word in bits [7:0]; the parser wants it in [31:24].
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mpeg_fifo_word_skid.sv
// Output stage covering the 1-cycle RAM read latency: a word is either in its
// RAM data phase or parked in the skid register, never both.
module mpeg_fifo_word_skid (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        issue,
  input  logic [31:0] ram_q,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        slot_free
);

  logic        r_pend;
  logic        r_skid_valid;
  logic [31:0] r_skid;

  assign out_valid = r_pend | r_skid_valid;
  assign out_data  = r_skid_valid ? r_skid : ram_q;
  // A new read may only be launched if the stage will be empty when its data
  // returns, so the returning word always has the skid register to fall into.
  assign slot_free = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_pend       <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_pend <= issue;
      if (r_pend && !out_ready) begin
        r_skid_valid <= 1'b1;
      end else if (r_skid_valid && out_ready) begin
        r_skid_valid <= 1'b0;
      end
    end
  end

  // NOTE: the skid data register is qualified by r_skid_valid, so it needs no
  // reset; leaving it out keeps the reset net off 32 data flops.
  always_ff @(posedge clk) begin
    if (r_pend && !out_ready) begin
      r_skid <= ram_q;
    end
  end

endmodule

// File: rtl/mpeg_input_stream_fifo_ctrl.sv
// Sequencing controller for the MPEG input-stream RAM: byte writes with
// end-of-stream zero padding, word reads presented through a skid stage.
module mpeg_input_stream_fifo_ctrl
  import mpeg_fifo_pkg::*;
#(
  parameter int ABITS     = FIFO_ABITS,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ABITS:0]    level,
  output logic              empty,
  output logic [ABITS-1:0]  ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [ABITS-3:0]  ram_raddr,
  input  logic [31:0]       ram_q
);

  localparam int             WABITS     = ABITS - 2;
  localparam logic [ABITS:0] LEVEL_FULL = {1'b1, {ABITS{1'b0}}};

  fifo_wr_state_e    r_state;
  logic [ABITS-1:0]  r_wptr;
  logic [WABITS-1:0] r_rd_issue_ptr;
  logic [ABITS:0]    r_level;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_pad_wr;
  logic              w_wr;
  logic              w_issue;
  logic              w_slot_free;
  logic              w_out_valid;
  logic              w_pop;
  logic [ABITS-1:0]  w_wptr_next;
  logic [WABITS-1:0] w_words_ready;
  logic [31:0]       w_ram_word;
  logic [31:0]       w_out_data;

  // reset_n gates in_ready directly so the handshake closes the moment reset asserts.
  assign w_in_ready    = reset_n && !flush && (r_state == IDLE) && (r_level != LEVEL_FULL);
  assign w_accept      = in_valid && w_in_ready;
  assign w_pad_wr      = (r_state == PAD) && !flush;
  assign w_wr          = w_accept || w_pad_wr;
  assign w_wptr_next   = r_wptr + 1'b1;

  // Registered wptr only counts words completed in an earlier cycle, which
  // keeps reads off any word still being written.
  assign w_words_ready = r_wptr[ABITS-1:2] - r_rd_issue_ptr;
  assign w_issue       = !flush && (w_words_ready != '0) && w_slot_free;
  assign w_pop         = w_out_valid && out_ready;
  assign w_ram_word    = BYTE_SWAP ? swap_bytes(ram_q) : ram_q;

  mpeg_fifo_word_skid u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .issue     (w_issue),
    .ram_q     (w_ram_word),
    .out_ready (out_ready),
    .out_valid (w_out_valid),
    .out_data  (w_out_data),
    .slot_free (w_slot_free)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_wptr         <= '0;
      r_rd_issue_ptr <= '0;
      r_level        <= '0;
    end else if (flush) begin
      r_state        <= IDLE;
      r_wptr         <= '0;
      r_rd_issue_ptr <= '0;
      r_level        <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= w_wptr_next;
      end
      if (w_issue) begin
        r_rd_issue_ptr <= r_rd_issue_ptr + 1'b1;
      end
      r_level <= r_level + {{ABITS{1'b0}}, w_wr} - {{(ABITS-2){1'b0}}, w_pop, 2'b00};

      if (r_state == IDLE) begin
        if (w_accept && in_last && (w_wptr_next[1:0] != 2'b00)) begin
          r_state <= PAD;
        end
      end else begin
        if (w_wptr_next[1:0] == 2'b00) begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign level     = r_level;
  assign empty     = (r_level == '0);
  assign ram_we    = w_wr;
  assign ram_waddr = r_wptr;
  assign ram_wdata = (r_state == PAD) ? 8'h00 : in_data;
  assign ram_raddr = r_rd_issue_ptr;

endmodule

// File: tb/tb_mpeg_input_stream_fifo_ctrl.sv
// Directed bench for mpeg_input_stream_fifo_ctrl with a little-endian RAM model
// and an in-order scoreboard of expected big-endian output words.
`timescale 1ns/1ps
module tb_mpeg_input_stream_fifo_ctrl;
  import mpeg_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  level_t      level;
  logic        empty;
  byte_addr_t  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  word_addr_t  ram_raddr;
  logic [31:0] ram_q;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_valid_cyc;
  int acc4_cyc;
  int drain_n;
  bit chk_stable = 1'b0;
  bit prev_stall = 1'b0;
  bit done4;
  logic [31:0] prev_data;
  logic [31:0] exp_q[$];
  logic [31:0] acc;

  mpeg_input_stream_fifo_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .empty     (empty),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Byte-wide write, word-wide registered read; byte a lives in lane a[1:0].
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr[14:2]][8*ram_waddr[1:0] +: 8] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (chk_stable && prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_word_cnt", exp_q.size(), 1);
        else                   check("word", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(output int cycles, input int budget);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(i ^ (i >> 8));
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b0; first_valid_cyc = -1;

    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_raddr", ram_raddr, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", in_ready, 1'b1);

    // Eight bytes with the reader stalled, then drain one word at a time.
    @(posedge clk); #1;
    first_valid_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), 1'b0);
      if (i == 3) acc4_cyc = cyc;
    end
    exp_q.push_back(32'h00010203);
    exp_q.push_back(32'h04050607);
    @(negedge clk);
    check("t1_level8", level, 8);
    // cyc counts edges: 4th byte at edge N, word visible after edge N+1.
    check("t1_latency", first_valid_cyc, acc4_cyc + 1);
    check("t1_head", out_data, 32'h00010203);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); check("t1_level_a", level, 8);
    @(negedge clk); check("t1_level_b", level, 4);
    @(negedge clk); check("t1_level_c", level, 0);
    check("t1_empty", empty, 1'b1);

    // End of stream on a misaligned byte: three pad cycles.
    @(posedge clk); #1;
    exp_q.push_back(32'hA0A1A2A3);
    exp_q.push_back(32'hA4000000);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), i == 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_pad_ready", in_ready, 1'b0);
      check("t2_pad_we", ram_we, 1'b1);
      check("t2_pad_data", ram_wdata, 8'h00);
      check("t2_pad_addr", ram_waddr, 13 + k);
    end
    @(negedge clk);
    check("t2_idle_ready", in_ready, 1'b1);
    check("t2_idle_we", ram_we, 1'b0);
    wait_drain(drain_n, 50);
    check("t2_level", level, 0);

    // Fill the whole RAM with the reader stalled; wptr wraps through 0.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 8192; k++)
      exp_q.push_back({fill_byte(4*k), fill_byte(4*k+1), fill_byte(4*k+2), fill_byte(4*k+3)});
    for (int i = 0; i < 32768; i++) send_byte(fill_byte(i), 1'b0);
    @(negedge clk);
    check("t3_full_level", level, 16'h8000);
    check("t3_full_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk); check("t3_full_ready2", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_no_accept", level, 16'h8000);
    check("t3_no_we", ram_we, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t3_pop_level", level, 16'h8000 - 4);
    check("t3_pop_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) send_byte(8'hC0 + 8'(j), 1'b0);
    exp_q.push_back(32'hC0C1C2C3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(drain_n, 20000);
    check("t3_throughput", drain_n <= 8194, 1'b1);
    @(negedge clk); check("t3_level", level, 0);

    // Incrementing stream with a randomly stalling reader.
    @(posedge clk); #1;
    chk_stable = 1'b1;
    done4 = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send_byte(8'(i), i == 999);
          acc = {acc[23:0], 8'(i)};
          if (i % 4 == 3) exp_q.push_back(acc);
        end
        done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(drain_n, 200);
    chk_stable = 1'b0;
    @(negedge clk); check("t4_level", level, 0);

    // Flush with one word presented, one read in flight and a byte offered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_q.push_back(32'h80818283);
    for (int i = 0; i < 12; i++) send_byte(8'h80 + 8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    check("t5_flush_ready", in_ready, 1'b0);
    check("t5_inflight", out_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_level", level, 0);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_empty", empty, 1'b1);
    check("t5_raddr", ram_raddr, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(32'h11121314);
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
    wait_drain(drain_n, 50);

    // Asynchronous reset with 12 bytes stored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'h30 + 8'(i), 1'b0);
    @(negedge clk); check("t6_level12", level, 12);
    @(posedge clk); #3;
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    #1;
    check("t6_async_level", level, 0);
    check("t6_async_empty", empty, 1'b1);
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_ready", in_ready, 1'b0);
    check("t6_async_we", ram_we, 1'b0);
    check("t6_async_raddr", ram_raddr, 0);
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_we", ram_we, 1'b0);
    check("t6_rst_level", level, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("t6_rel_ready", in_ready, 1'b1);
    check("t6_rel_waddr", ram_waddr, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(32'h51525354);
    exp_q.push_back(32'h55565758);
    for (int i = 0; i < 8; i++) send_byte(8'h51 + 8'(i), 1'b0);
    wait_drain(drain_n, 50);
    @(negedge clk); check("t6_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
